// File: rtl/mshr_chain.sv
// Miss status holding register with free-list allocation and per-address chains.
// Primary misses issue memory requests; secondary misses link behind the chain
// tail. A fill releases its chain, which then replays one entry per cycle.
module mshr_chain #(
  parameter int unsigned MSHR_SIZE       = 8,
  parameter int unsigned LINE_ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ALM_FULL        = MSHR_SIZE - 1,
  parameter int unsigned IDW             = $clog2(MSHR_SIZE),
  parameter int unsigned CNTW            = $clog2(MSHR_SIZE + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       allocate_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
  input  logic [DATA_WIDTH-1:0]      allocate_data,
  output logic                       allocate_ready,
  output logic [IDW-1:0]             allocate_id,
  output logic                       allocate_pending,
  input  logic                       fill_valid,
  input  logic [IDW-1:0]             fill_id,
  output logic                       fill_ready,
  output logic                       dequeue_valid,
  output logic [IDW-1:0]             dequeue_id,
  output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
  output logic [DATA_WIDTH-1:0]      dequeue_data,
  input  logic                       dequeue_ready,
  output logic                       full,
  output logic                       almost_full,
  output logic [CNTW-1:0]            count
);

  typedef enum logic [0:0] {StIdle, StReplay} state_e;

  state_e state_q, state_d;

  logic [MSHR_SIZE-1:0]       valid_q, waiting_q, has_next_q;
  logic [IDW-1:0]             next_q [MSHR_SIZE];
  logic [LINE_ADDR_WIDTH-1:0] addr_q [MSHR_SIZE];
  logic [DATA_WIDTH-1:0]      data_q [MSHR_SIZE];
  logic [IDW-1:0]             dequeue_ptr_q;
  logic [CNTW-1:0]            count_q, count_d;

  logic                       allocate_fire, fill_fire, dequeue_fire;
  logic [LINE_ADDR_WIDTH-1:0] fill_addr;
  logic [MSHR_SIZE-1:0]       released;
  logic                       tail_hit;
  logic [IDW-1:0]             tail_id;
  logic                       free_found;
  logic [IDW-1:0]             free_id;

  assign allocate_fire = allocate_valid && allocate_ready;
  assign fill_fire     = fill_valid && fill_ready;
  assign dequeue_fire  = dequeue_valid && dequeue_ready;
  assign fill_addr     = addr_q[fill_id];

  // Lowest free index; entries freed this cycle only become visible next cycle.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_id    = IDW'(i);
      end
    end
  end

  // Find the waiting chain tail for the incoming address, ignoring chains this fill releases.
  always_comb begin
    released = '0;
    tail_hit = 1'b0;
    tail_id  = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      released[i] = fill_fire && valid_q[i] && (addr_q[i] == fill_addr);
      if (valid_q[i] && waiting_q[i] && !has_next_q[i] && !released[i] &&
          (addr_q[i] == allocate_addr)) begin
        tail_hit = 1'b1;
        tail_id  = IDW'(i);
      end
    end
  end

  assign allocate_id      = free_id;
  assign allocate_pending = tail_hit;
  assign allocate_ready   = !full;
  assign full             = (count_q == CNTW'(MSHR_SIZE));
  assign almost_full      = (count_q >= CNTW'(ALM_FULL));
  assign count            = count_q;

  assign dequeue_id   = dequeue_ptr_q;
  assign dequeue_addr = addr_q[dequeue_ptr_q];
  assign dequeue_data = data_q[dequeue_ptr_q];

  // Replay engine state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Replay engine next state: leave replay after dequeuing the chain's last entry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fill_fire) state_d = StReplay;
      StReplay: if (dequeue_fire && !has_next_q[dequeue_ptr_q]) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Replay engine outputs
  always_comb begin
    fill_ready    = (state_q == StIdle);
    dequeue_valid = (state_q == StReplay);
  end

  // Replay pointer: start at the filled primary, then follow next links
  always_ff @(posedge clk) begin
    if (reset) begin
      dequeue_ptr_q <= '0;
    end else if (fill_fire) begin
      dequeue_ptr_q <= fill_id;
    end else if (dequeue_fire && has_next_q[dequeue_ptr_q]) begin
      dequeue_ptr_q <= next_q[dequeue_ptr_q];
    end
  end

  // Occupancy counter
  always_comb begin
    count_d = count_q + CNTW'(allocate_fire) - CNTW'(dequeue_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Entry array: fill release, dequeue free, allocate and tail link
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      waiting_q  <= '0;
      has_next_q <= '0;
    end else begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        if (released[i]) waiting_q[i] <= 1'b0;
      end
      if (dequeue_fire) begin
        valid_q[dequeue_ptr_q]    <= 1'b0;
        has_next_q[dequeue_ptr_q] <= 1'b0;
      end
      if (allocate_fire) begin
        valid_q[allocate_id]    <= 1'b1;
        waiting_q[allocate_id]  <= 1'b1;
        has_next_q[allocate_id] <= 1'b0;
        addr_q[allocate_id]     <= allocate_addr;
        data_q[allocate_id]     <= allocate_data;
        if (tail_hit) begin
          has_next_q[tail_id] <= 1'b1;
          next_q[tail_id]     <= allocate_id;
        end
      end
    end
  end

  // Protocol checks
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_fire) begin
        assert (valid_q[fill_id] && waiting_q[fill_id])
          else $error("mshr_chain: fill to invalid or non-waiting id %0d", fill_id);
      end
      assert (!(allocate_fire && full)) else $error("mshr_chain: allocate while full");
      assert (!(dequeue_fire && state_q != StReplay))
        else $error("mshr_chain: dequeue while replay idle");
    end
  end

endmodule

// File: tb/tb_mshr_chain.sv
// Directed self-checking bench for mshr_chain. Inputs change just after the
// falling edge; outputs are checked 1ns later, away from the rising edge.
module tb_mshr_chain;
  localparam int unsigned N    = 8;
  localparam int unsigned AW   = 26;
  localparam int unsigned DW   = 64;
  localparam int unsigned IDW  = 3;
  localparam int unsigned CNTW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           allocate_valid;
  logic [AW-1:0]  allocate_addr;
  logic [DW-1:0]  allocate_data;
  logic           allocate_ready;
  logic [IDW-1:0] allocate_id;
  logic           allocate_pending;
  logic           fill_valid;
  logic [IDW-1:0] fill_id;
  logic           fill_ready;
  logic           dequeue_valid;
  logic [IDW-1:0] dequeue_id;
  logic [AW-1:0]  dequeue_addr;
  logic [DW-1:0]  dequeue_data;
  logic           dequeue_ready;
  logic           full;
  logic           almost_full;
  logic [CNTW-1:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mshr_chain dut (
    .clk(clk), .reset(reset),
    .allocate_valid(allocate_valid), .allocate_addr(allocate_addr),
    .allocate_data(allocate_data), .allocate_ready(allocate_ready),
    .allocate_id(allocate_id), .allocate_pending(allocate_pending),
    .fill_valid(fill_valid), .fill_id(fill_id), .fill_ready(fill_ready),
    .dequeue_valid(dequeue_valid), .dequeue_id(dequeue_id),
    .dequeue_addr(dequeue_addr), .dequeue_data(dequeue_data),
    .dequeue_ready(dequeue_ready), .full(full), .almost_full(almost_full),
    .count(count)
  );

  function automatic logic [DW-1:0] pay(input int unsigned k);
    pay = 64'hD00D_0000_0000_0000 | DW'(k);
  endfunction

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; allocate_valid = 1'b0; allocate_addr = '0; allocate_data = '0;
    fill_valid = 1'b0; fill_id = '0; dequeue_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one allocate for a cycle and check the id/pending it is offered.
  task automatic alloc(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [IDW-1:0] exp_id, input logic exp_pend);
    allocate_valid = 1'b1; allocate_addr = a; allocate_data = d;
    #1;
    tests++;
    if (allocate_id !== exp_id) begin
      fails++; $display("FAIL alloc_id addr=%0h: got %0d expected %0d", a, allocate_id, exp_id);
    end
    tests++;
    if (allocate_pending !== exp_pend) begin
      fails++;
      $display("FAIL alloc_pending addr=%0h: got %0b expected %0b", a, allocate_pending, exp_pend);
    end
    @(negedge clk);
    allocate_valid = 1'b0;
  endtask

  task automatic fill(input logic [IDW-1:0] id);
    fill_valid = 1'b1; fill_id = id;
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  // Expect one replay beat now; it is accepted at the next rising edge (dequeue_ready=1).
  task automatic expect_deq(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    #1;
    tests++;
    if (dequeue_valid !== 1'b1 || dequeue_id !== id || dequeue_addr !== a || dequeue_data !== d)
    begin
      fails++;
      $display("FAIL dequeue: got v=%0b id=%0d a=%0h d=%0h expected v=1 id=%0d a=%0h d=%0h",
               dequeue_valid, dequeue_id, dequeue_addr, dequeue_data, id, a, d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({allocate_ready, allocate_id, allocate_pending, fill_ready, dequeue_valid, full,
         almost_full, count} !== {1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%0b id=%0d pend=%0b frdy=%0b dv=%0b full=%0b af=%0b cnt=%0d expected 1 0 0 1 0 0 0 0",
               allocate_ready, allocate_id, allocate_pending, fill_ready, dequeue_valid, full,
               almost_full, count);
    end
    @(negedge clk);
    alloc(26'h10, pay(0), 3'd0, 1'b0);
    #1;
    tests++;
    if (count !== 4'd1) begin fails++; $display("FAIL first_count: got %0d expected 1", count); end
    @(negedge clk);
  endtask

  task automatic test_chain();
    do_reset();
    for (int i = 0; i < 3; i++) alloc(26'h10, pay(16 + i), IDW'(i), i != 0);
    fill_valid = 1'b1; fill_id = 3'd0;
    #1;
    tests++;
    if (dequeue_valid !== 1'b0 || fill_ready !== 1'b1) begin
      fails++;
      $display("FAIL chain_fill_cycle: got dv=%0b frdy=%0b expected dv=0 frdy=1",
               dequeue_valid, fill_ready);
    end
    @(negedge clk);
    fill_valid = 1'b0;
    #1;
    tests++;
    if (fill_ready !== 1'b0 || count !== 4'd3) begin
      fails++;
      $display("FAIL chain_busy: got frdy=%0b cnt=%0d expected frdy=0 cnt=3", fill_ready, count);
    end
    for (int i = 0; i < 3; i++) expect_deq(IDW'(i), 26'h10, pay(16 + i));
    #1;
    tests++;
    if (dequeue_valid !== 1'b0 || fill_ready !== 1'b1 || count !== 4'd0) begin
      fails++;
      $display("FAIL chain_done: got dv=%0b frdy=%0b cnt=%0d expected dv=0 frdy=1 cnt=0",
               dequeue_valid, fill_ready, count);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc(26'h20, pay(32), 3'd0, 1'b0);
    alloc(26'h30, pay(48), 3'd1, 1'b0);
    alloc(26'h20, pay(33), 3'd2, 1'b1);
    alloc(26'h30, pay(49), 3'd3, 1'b1);
    fill(3'd1);
    expect_deq(3'd1, 26'h30, pay(48));
    expect_deq(3'd3, 26'h30, pay(49));
    #1;
    tests++;
    if (dequeue_valid !== 1'b0 || count !== 4'd2) begin
      fails++;
      $display("FAIL ooo_mid: got dv=%0b cnt=%0d expected dv=0 cnt=2", dequeue_valid, count);
    end
    @(negedge clk);
    fill(3'd0);
    expect_deq(3'd0, 26'h20, pay(32));
    expect_deq(3'd2, 26'h20, pay(33));
    #1;
    tests++;
    if (dequeue_valid !== 1'b0 || count !== 4'd0) begin
      fails++;
      $display("FAIL ooo_done: got dv=%0b cnt=%0d expected dv=0 cnt=0", dequeue_valid, count);
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    do_reset();
    alloc(26'h40, pay(64), 3'd0, 1'b0);
    fill_valid = 1'b1; fill_id = 3'd0;
    alloc(26'h40, pay(65), 3'd1, 1'b0);
    fill_valid = 1'b0;
    expect_deq(3'd0, 26'h40, pay(64));
    // Entry 1 must still be a waiting tail: a new 0x40 miss would link behind it.
    allocate_addr = 26'h40;
    #1;
    tests++;
    if (dequeue_valid !== 1'b0 || allocate_pending !== 1'b1) begin
      fails++;
      $display("FAIL same_cycle_waiting: got dv=%0b pend=%0b expected dv=0 pend=1",
               dequeue_valid, allocate_pending);
    end
    @(negedge clk);
    fill(3'd1);
    expect_deq(3'd1, 26'h40, pay(65));
    #1;
    tests++;
    if (dequeue_valid !== 1'b0 || count !== 4'd0) begin
      fails++;
      $display("FAIL same_cycle_alone: got dv=%0b cnt=%0d expected dv=0 cnt=0",
               dequeue_valid, count);
    end
    @(negedge clk);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < N; i++) begin
      alloc(AW'(256 + i), pay(256 + i), IDW'(i), 1'b0);
      #1;
      tests++;
      if (count !== CNTW'(i + 1) || almost_full !== (i + 1 >= N - 1) || full !== (i + 1 == N))
      begin
        fails++;
        $display("FAIL fill_up step %0d: got cnt=%0d af=%0b full=%0b expected cnt=%0d af=%0b full=%0b",
                 i, count, almost_full, full, i + 1, i + 1 >= N - 1, i + 1 == N);
      end
      @(negedge clk);
    end
    tests++;
    if (allocate_ready !== 1'b0) begin
      fails++; $display("FAIL full_ready: got %0b expected 0", allocate_ready);
    end
    dequeue_ready = 1'b0;
    fill(3'd3);
    // Stalled allocate alongside the dequeue of entry 3.
    allocate_valid = 1'b1; allocate_addr = 26'h200; allocate_data = pay(512);
    dequeue_ready = 1'b1;
    #1;
    tests++;
    if (dequeue_valid !== 1'b1 || dequeue_id !== 3'd3 || allocate_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_dequeue: got dv=%0b id=%0d rdy=%0b expected dv=1 id=3 rdy=0",
               dequeue_valid, dequeue_id, allocate_ready);
    end
    @(negedge clk);
    #1;
    tests++;
    if (full !== 1'b0 || count !== 4'd7 || allocate_ready !== 1'b1 || allocate_id !== 3'd3)
    begin
      fails++;
      $display("FAIL full_freed: got full=%0b cnt=%0d rdy=%0b id=%0d expected 0 7 1 3",
               full, count, allocate_ready, allocate_id);
    end
    @(negedge clk);
    allocate_valid = 1'b0;
    #1;
    tests++;
    if (full !== 1'b1 || count !== 4'd8 || dequeue_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_refill: got full=%0b cnt=%0d dv=%0b expected full=1 cnt=8 dv=0",
               full, count, dequeue_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) alloc(26'h50, pay(80 + i), IDW'(i), i != 0);
    alloc(26'h60, pay(96), 3'd3, 1'b0);
    dequeue_ready = 1'b0;
    fill(3'd0);
    dequeue_ready = 1'b1;
    expect_deq(3'd0, 26'h50, pay(80));
    dequeue_ready = 1'b0;
    fill_valid = 1'b1; fill_id = 3'd3;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (dequeue_valid !== 1'b1 || dequeue_id !== 3'd1 || dequeue_data !== pay(81) ||
          fill_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall cycle %0d: got dv=%0b id=%0d d=%0h frdy=%0b expected 1 1 %0h 0",
                 c, dequeue_valid, dequeue_id, dequeue_data, fill_ready, pay(81));
      end
      @(negedge clk);
    end
    fill_valid = 1'b0;
    dequeue_ready = 1'b1;
    expect_deq(3'd1, 26'h50, pay(81));
    expect_deq(3'd2, 26'h50, pay(82));
    // Blocked fill must not have released 0x60: it is still a waiting tail.
    allocate_addr = 26'h60;
    #1;
    tests++;
    if (dequeue_valid !== 1'b0 || fill_ready !== 1'b1 || count !== 4'd1 ||
        allocate_pending !== 1'b1) begin
      fails++;
      $display("FAIL stall_after: got dv=%0b frdy=%0b cnt=%0d pend=%0b expected 0 1 1 1",
               dequeue_valid, fill_ready, count, allocate_pending);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_chain();
    test_out_of_order();
    test_same_cycle();
    test_full();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mshr_chain.md
Name: mshr_chain

Overview:
- Next-generation miss status holding register for a cache bank.
- Entries are allocated from a free list rather than FIFO order.
- Secondary misses to a line address already waiting on memory are linked into a per-address chain, so only primary misses issue memory requests.
- A fill response releases the whole chain, which is then replayed to the bank pipeline in allocation order, one entry per cycle. Multiple independent chains may be outstanding and fill out of order.

Parameters:
- MSHR_SIZE, 8, number of entries; must be >= 2.
- LINE_ADDR_WIDTH, 26, line address width.
- DATA_WIDTH, 64, per-entry request payload width (tag, word select, byte enable, write data).
- ALM_FULL, MSHR_SIZE-1, occupancy at which almost_full asserts.
- IDW, $clog2(MSHR_SIZE), entry id width (derived).
- CNTW, $clog2(MSHR_SIZE+1), occupancy counter width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- allocate_valid  in  1  new miss request
- allocate_addr  in  LINE_ADDR_WIDTH  miss line address
- allocate_data  in  DATA_WIDTH  request payload
- allocate_ready  out  1  entry available (= !full)
- allocate_id  out  IDW  entry id to be used by this allocation (lowest free index)
- allocate_pending  out  1  1 = secondary miss, linked to a waiting chain; no memory request needed
- fill_valid  in  1  memory response arrived
- fill_id  in  IDW  id of the primary entry whose request returned
- fill_ready  out  1  replay engine idle
- dequeue_valid  out  1  replay entry available
- dequeue_id  out  IDW  replaying entry id
- dequeue_addr  out  LINE_ADDR_WIDTH  replay line address
- dequeue_data  out  DATA_WIDTH  replay payload
- dequeue_ready  in  1  bank accepts replay
- full  out  1  all entries valid
- almost_full  out  1  count >= ALM_FULL
- count  out  CNTW  valid entry count

Behaviour:
- Per-entry state:
  - valid, waiting (fill not yet received), has_next (next-valid flag), next (IDW), addr, data.
  - Registered arrays, no RAM macro; dequeue outputs are combinational reads at dequeue_ptr.
- Reset:
  - All valid/waiting/has_next cleared; replay engine idle; count=0.
  - Outputs at reset: allocate_ready=1, allocate_id=0, allocate_pending=0, fill_ready=1, dequeue_valid=0, full=0, almost_full=0 (ALM_FULL>0).
  - Reset mid-chain discards all entries with no further outputs.
- Allocate fires when allocate_valid && allocate_ready. The entry at allocate_id becomes valid and waiting with has_next=0.
- Match and linking:
  - Match = a valid, waiting entry with has_next=0 and addr==allocate_addr; at most one such tail exists.
  - On match: allocate_pending=1 combinationally, and at the clock edge tail.next<=allocate_id, tail.has_next<=1.
- Fill fires when fill_valid && fill_ready.
  - Clears waiting on every valid entry whose addr==addr[fill_id] (CAM, 1 cycle).
  - Sets dequeue_ptr<=fill_id and replay_active<=1.
  - fill_ready = !replay_active.
  - A fill to an invalid or non-waiting id is an assertion error.
- Replay:
  - dequeue_valid = replay_active.
  - On dequeue fire: entry[dequeue_ptr] is freed (valid<=0, has_next<=0).
  - If has_next, dequeue_ptr<=next; otherwise replay_active<=0.
  - Latency: fill accepted at cycle T, first dequeue_valid at T+1. A chain of N entries drains in N cycles with dequeue_ready held high. fill_ready returns at the cycle after the last dequeue.
- Allocate and fill to the same addr in the same cycle:
  - Match excludes entries released by this fill.
  - The new entry becomes a new primary: allocate_pending=0, and it stays waiting.
- Allocate and dequeue in the same cycle:
  - The entry freed by the dequeue is not visible to the free-list encoder until the next cycle.
  - count is unchanged; full and almost_full are recomputed from the next count.
- count arithmetic: count_n = count + allocate_fire - dequeue_fire. full = (count==MSHR_SIZE). almost_full = (count>=ALM_FULL).
- Assertions: no allocate while full; no dequeue fire while !replay_active.

Test Plan:
- Reset, then allocate addr 0x10 -> allocate_id=0, allocate_pending=0; count=1 next cycle.
- Allocate 0x10 three times (ids 0,1,2), fill_id=0 -> dequeue_valid at T+1; dequeue_id sequence 0,1,2 over 3 cycles with payloads in order; fill_ready re-asserts after the last one; count=0.
- Two chains (0x20 on ids 0,2; 0x30 on ids 1,3); fill_id=1 first -> replay 1,3. Then fill_id=0 -> replay 0,2. Out-of-order fills work.
- Fill 0x40 and allocate 0x40 in the same cycle -> allocate_pending=0; the new entry stays waiting, and a second fill on its id replays it alone.
- Fill MSHR_SIZE distinct addresses -> full=1, allocate_ready=0, almost_full=1 from count=ALM_FULL. A dequeue plus a stalled allocate in the same cycle -> full=0 the next cycle, and the allocate then succeeds with the freed id.
- dequeue_ready held low 5 cycles mid-chain -> dequeue_id and dequeue_data stable, fill_ready=0, and a new fill is back-pressured.
